// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_fifo
//  Description : UART receiver with a first-word-fall-through receive FIFO.
//                The serial line is resynchronised, framed by a mid-bit
//                sampling FSM (start / data / optional parity / stop), and
//                good words are pushed into a small circular FIFO. Framing,
//                parity and overrun problems are reported as one-cycle
//                pulses.
//
//  Parameters  : CLKS_PER_BIT  clk cycles per serial bit (>= 8)
//                DATA_BITS     data bits per frame (5..9), LSB first
//                PARITY        0 = none, 1 = odd, 2 = even
//                STOP_BITS     stop bits checked per frame (1 or 2)
//                FIFO_DEPTH    receive FIFO entries (power of 2, >= 2)
//
//  Ports       : clk         rising-edge clock for all logic
//                reset       synchronous, active-high reset
//                UART_RX     asynchronous serial input, idle high
//                rd_en       pop the head entry (ignored while empty)
//                rd_data     head entry, valid while empty = 0
//                empty/full  FIFO occupancy flags (derived from count)
//                count       FIFO occupancy
//                frame_err   pulse: a stop bit was sampled low
//                parity_err  pulse: parity check failed, frame dropped
//                overrun     pulse: good frame dropped, FIFO full
//
//  Revision    : 1.0  initial release
// ============================================================================
module uart_rx_fifo #(
    parameter int CLKS_PER_BIT = 5208,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          UART_RX,
    input  logic                          rd_en,
    output logic [DATA_BITS-1:0]          rd_data,
    output logic                          empty,
    output logic                          full,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          frame_err,
    output logic                          parity_err,
    output logic                          overrun
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int c_TMR_W = $clog2(CLKS_PER_BIT);
    localparam int c_PTR_W = $clog2(FIFO_DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam int c_IDX_W = 4;

    // The timer is cleared on the cycle after each sample, so a sample that
    // must land N cycles after the previous one fires when the timer reads N-1.
    localparam logic [c_TMR_W-1:0] c_HALF_M1  = c_TMR_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [c_TMR_W-1:0] c_FULL_M1  = c_TMR_W'(CLKS_PER_BIT - 1);
    localparam logic [c_IDX_W-1:0] c_LAST_DAT = c_IDX_W'(DATA_BITS - 1);
    localparam logic [c_IDX_W-1:0] c_LAST_STP = c_IDX_W'(STOP_BITS - 1);
    localparam logic [c_CNT_W-1:0] c_DEPTH    = c_CNT_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_START   = 3'd1,
        S_DATA    = 3'd2,
        S_PAR     = 3'd3,
        S_STOP    = 3'd4,
        S_WAIT_HI = 3'd5
    } state_t;

    // ------------------------------------------------------------------------
    // Input synchroniser
    // ------------------------------------------------------------------------
    logic r_sync1_q, r_sync2_q;
    logic w_sync1_d, w_sync2_d;
    logic w_rxs;

    always_comb begin
        w_sync1_d = UART_RX;
        w_sync2_d = r_sync1_q;
    end

    // Flops reset to the idle (high) line level so reset never fakes a start bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1_q <= 1'b1;
            r_sync2_q <= 1'b1;
        end else begin
            r_sync1_q <= w_sync1_d;
            r_sync2_q <= w_sync2_d;
        end
    end

    assign w_rxs = r_sync2_q;

    // ------------------------------------------------------------------------
    // Receive FSM
    // ------------------------------------------------------------------------
    state_t                 r_state_q,      w_state_d;
    logic [c_TMR_W-1:0]     r_timer_q,      w_timer_d;
    logic [c_IDX_W-1:0]     r_idx_q,        w_idx_d;
    logic [DATA_BITS-1:0]   r_shift_q,      w_shift_d;
    logic                   r_par_q,        w_par_d;
    logic                   r_par_ok_q,     w_par_ok_d;
    logic                   r_push_q,       w_push_d;
    logic                   r_frame_err_q,  w_frame_err_d;
    logic                   r_parity_err_q, w_parity_err_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_q      <= S_IDLE;
            r_timer_q      <= '0;
            r_idx_q        <= '0;
            r_shift_q      <= '0;
            r_par_q        <= 1'b0;
            r_par_ok_q     <= 1'b0;
            r_push_q       <= 1'b0;
            r_frame_err_q  <= 1'b0;
            r_parity_err_q <= 1'b0;
        end else begin
            r_state_q      <= w_state_d;
            r_timer_q      <= w_timer_d;
            r_idx_q        <= w_idx_d;
            r_shift_q      <= w_shift_d;
            r_par_q        <= w_par_d;
            r_par_ok_q     <= w_par_ok_d;
            r_push_q       <= w_push_d;
            r_frame_err_q  <= w_frame_err_d;
            r_parity_err_q <= w_parity_err_d;
        end
    end

    always_comb begin
        w_state_d      = r_state_q;
        w_timer_d      = r_timer_q + c_TMR_W'(1);
        w_idx_d        = r_idx_q;
        w_shift_d      = r_shift_q;
        w_par_d        = r_par_q;
        w_par_ok_d     = r_par_ok_q;
        w_push_d       = 1'b0;
        w_frame_err_d  = 1'b0;
        w_parity_err_d = 1'b0;

        case (r_state_q)
            S_IDLE: begin
                w_timer_d = '0;
                if (!w_rxs) begin
                    w_state_d = S_START;
                    w_idx_d   = '0;
                    w_par_d   = 1'b0;
                end
            end

            // Mid-start-bit check: a line already back high was a glitch.
            S_START: begin
                if (r_timer_q == c_HALF_M1) begin
                    w_timer_d = '0;
                    w_state_d = w_rxs ? S_IDLE : S_DATA;
                end
            end

            // LSB arrives first, so shift in at the top and move right.
            S_DATA: begin
                if (r_timer_q == c_FULL_M1) begin
                    w_timer_d = '0;
                    w_shift_d = {w_rxs, r_shift_q[DATA_BITS-1:1]};
                    w_par_d   = r_par_q ^ w_rxs;
                    if (r_idx_q == c_LAST_DAT) begin
                        w_idx_d    = '0;
                        w_par_ok_d = 1'b1;
                        w_state_d  = (PARITY != 0) ? S_PAR : S_STOP;
                    end else begin
                        w_idx_d = r_idx_q + c_IDX_W'(1);
                    end
                end
            end

            // Verdict is held until the stop bits are known, because a bad
            // stop bit outranks a parity failure.
            S_PAR: begin
                if (r_timer_q == c_FULL_M1) begin
                    w_timer_d  = '0;
                    w_par_ok_d = (PARITY == 1) ?  (r_par_q ^ w_rxs)
                                               : ~(r_par_q ^ w_rxs);
                    w_state_d  = S_STOP;
                end
            end

            // Returning to IDLE at mid-stop-bit lets the next start edge be
            // caught even when frames are sent back to back.
            S_STOP: begin
                if (r_timer_q == c_FULL_M1) begin
                    w_timer_d = '0;
                    if (!w_rxs) begin
                        w_frame_err_d = 1'b1;
                        w_state_d     = S_WAIT_HI;
                    end else if (r_idx_q == c_LAST_STP) begin
                        w_state_d = S_IDLE;
                        if (r_par_ok_q) begin
                            w_push_d = 1'b1;
                        end else begin
                            w_parity_err_d = 1'b1;
                        end
                    end else begin
                        w_idx_d = r_idx_q + c_IDX_W'(1);
                    end
                end
            end

            // A held-low line (break) must not re-trigger framing errors.
            S_WAIT_HI: begin
                w_timer_d = '0;
                if (w_rxs) begin
                    w_state_d = S_IDLE;
                end
            end

            default: begin
                w_state_d = S_IDLE;
                w_timer_d = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Receive FIFO
    // ------------------------------------------------------------------------
    // r_shift_q is stable for at least half a bit after the final stop
    // sample, so it can be written directly on the push cycle.
    logic [DATA_BITS-1:0]   r_mem_q [FIFO_DEPTH];
    logic [c_PTR_W-1:0]     r_wr_ptr_q,  w_wr_ptr_d;
    logic [c_PTR_W-1:0]     r_rd_ptr_q,  w_rd_ptr_d;
    logic [c_CNT_W-1:0]     r_count_q,   w_count_d;
    logic                   r_overrun_q, w_overrun_d;
    logic                   w_empty, w_full;
    logic                   w_do_pop, w_do_push;

    assign w_empty = (r_count_q == '0);
    assign w_full  = (r_count_q == c_DEPTH);

    // A pop in the same cycle frees the slot, so a push into a full FIFO
    // is still accepted when rd_en is high.
    always_comb begin
        w_do_pop    = rd_en && !w_empty;
        w_do_push   = r_push_q && (!w_full || w_do_pop);
        w_overrun_d = r_push_q && w_full && !rd_en;

        w_wr_ptr_d  = r_wr_ptr_q;
        w_rd_ptr_d  = r_rd_ptr_q;
        w_count_d   = r_count_q;

        if (w_do_push) begin
            w_wr_ptr_d = r_wr_ptr_q + c_PTR_W'(1);
        end
        if (w_do_pop) begin
            w_rd_ptr_d = r_rd_ptr_q + c_PTR_W'(1);
        end

        case ({w_do_push, w_do_pop})
            2'b10:   w_count_d = r_count_q + c_CNT_W'(1);
            2'b01:   w_count_d = r_count_q - c_CNT_W'(1);
            default: w_count_d = r_count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr_q  <= '0;
            r_rd_ptr_q  <= '0;
            r_count_q   <= '0;
            r_overrun_q <= 1'b0;
        end else begin
            r_wr_ptr_q  <= w_wr_ptr_d;
            r_rd_ptr_q  <= w_rd_ptr_d;
            r_count_q   <= w_count_d;
            r_overrun_q <= w_overrun_d;
        end
    end

    // Storage needs no reset: entries are only visible once counted.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem_q[r_wr_ptr_q] <= r_shift_q;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign rd_data    = r_mem_q[r_rd_ptr_q];
    assign empty      = w_empty;
    assign full       = w_full;
    assign count      = r_count_q;
    assign frame_err  = r_frame_err_q;
    assign parity_err = r_parity_err_q;
    assign overrun    = r_overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_rx_fifo
//  Description : Self-checking bench for uart_rx_fifo. Four instances share
//                one clock: an 8N1 main instance, a 7-bit even-parity and a
//                7-bit odd-parity instance on a shared line, and an 8N2
//                instance. Expected words go into per-instance queues when
//                frames are sent and are compared as the FIFOs are drained.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_uart_rx_fifo;

    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] rx;

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // ---------------- main: 8N1, depth 4 ----------------
    logic       m_rd_en;
    logic [7:0] m_rd_data;
    logic       m_empty, m_full, m_fe, m_pe, m_ov;
    logic [2:0] m_count;

    uart_rx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_main (
        .clk(clk), .reset(reset), .UART_RX(rx[0]), .rd_en(m_rd_en), .rd_data(m_rd_data),
        .empty(m_empty), .full(m_full), .count(m_count),
        .frame_err(m_fe), .parity_err(m_pe), .overrun(m_ov));

    // ---------------- even: 7E1 ----------------
    logic       e_rd_en;
    logic [6:0] e_rd_data;
    logic       e_empty, e_full, e_fe, e_pe, e_ov;
    logic [2:0] e_count;

    uart_rx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) u_even (
        .clk(clk), .reset(reset), .UART_RX(rx[1]), .rd_en(e_rd_en), .rd_data(e_rd_data),
        .empty(e_empty), .full(e_full), .count(e_count),
        .frame_err(e_fe), .parity_err(e_pe), .overrun(e_ov));

    // ---------------- odd: 7O1 ----------------
    logic       o_rd_en;
    logic [6:0] o_rd_data;
    logic       o_empty, o_full, o_fe, o_pe, o_ov;
    logic [2:0] o_count;

    uart_rx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4)) u_odd (
        .clk(clk), .reset(reset), .UART_RX(rx[1]), .rd_en(o_rd_en), .rd_data(o_rd_data),
        .empty(o_empty), .full(o_full), .count(o_count),
        .frame_err(o_fe), .parity_err(o_pe), .overrun(o_ov));

    // ---------------- two: 8N2 ----------------
    logic       t_rd_en;
    logic [7:0] t_rd_data;
    logic       t_empty, t_full, t_fe, t_pe, t_ov;
    logic [2:0] t_count;

    uart_rx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(4)) u_two (
        .clk(clk), .reset(reset), .UART_RX(rx[2]), .rd_en(t_rd_en), .rd_data(t_rd_data),
        .empty(t_empty), .full(t_full), .count(t_count),
        .frame_err(t_fe), .parity_err(t_pe), .overrun(t_ov));

    // Pulse counters: a one-cycle pulse adds exactly one.
    int m_fe_n = 0, m_pe_n = 0, m_ov_n = 0;
    int e_fe_n = 0, e_pe_n = 0, o_fe_n = 0, o_pe_n = 0;
    int t_fe_n = 0, t_pe_n = 0;

    always @(negedge clk) begin
        if (m_fe === 1'b1) m_fe_n <= m_fe_n + 1;
        if (m_pe === 1'b1) m_pe_n <= m_pe_n + 1;
        if (m_ov === 1'b1) m_ov_n <= m_ov_n + 1;
        if (e_fe === 1'b1) e_fe_n <= e_fe_n + 1;
        if (e_pe === 1'b1) e_pe_n <= e_pe_n + 1;
        if (o_fe === 1'b1) o_fe_n <= o_fe_n + 1;
        if (o_pe === 1'b1) o_pe_n <= o_pe_n + 1;
        if (t_fe === 1'b1) t_fe_n <= t_fe_n + 1;
        if (t_pe === 1'b1) t_pe_n <= t_pe_n + 1;
    end

    // Scoreboards
    logic [7:0] q_main [$];
    logic [6:0] q_even [$];
    logic [6:0] q_odd  [$];
    logic [7:0] q_two  [$];

    // ---------------- stimulus helpers (called at a negedge) ----------------
    task automatic put(input int ln, input logic v);
        rx[ln] = v;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic drive_frame(input int ln, input logic [8:0] data, input int nbits,
                               input int pbit, input int nstop, input logic s2);
        put(ln, 1'b0);
        for (int i = 0; i < nbits; i++) put(ln, data[i]);
        if (pbit >= 0) put(ln, pbit[0]);
        put(ln, 1'b1);
        if (nstop == 2) put(ln, s2);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1;
        repeat (4) @(negedge clk);
        total++;
        if (m_empty !== 1'b1 || m_full !== 1'b0 || m_count !== 3'd0) begin
            bad++; $display("FAIL reset_flags_during: empty=%b full=%b count=%0d want 1 0 0", m_empty, m_full, m_count);
        end
        reset = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (m_empty !== 1'b1 || m_full !== 1'b0 || m_count !== 3'd0) begin
            bad++; $display("FAIL reset_flags_after: empty=%b full=%b count=%0d want 1 0 0", m_empty, m_full, m_count);
        end
        total++;
        if ({m_fe, m_pe, m_ov, t_fe, e_pe, o_pe} !== 6'b0) begin
            bad++; $display("FAIL reset_pulses: got %b want 000000", {m_fe, m_pe, m_ov, t_fe, e_pe, o_pe});
        end
    endtask

    task automatic test_defaults();
        drive_frame(0, 9'h054, 8, -1, 1, 1'b1); q_main.push_back(8'h54);
        put(0, 1'b1);
        drive_frame(0, 9'h00C, 8, -1, 1, 1'b1); q_main.push_back(8'h0C);
        put(0, 1'b1);
        total++;
        if (m_count !== 3'd2) begin
            bad++; $display("FAIL defaults_count: got %0d want 2", m_count);
        end
        for (int k = 0; k < 2; k++) begin
            logic [7:0] exp = q_main.pop_front();
            total++;
            if (m_empty !== 1'b0 || m_rd_data !== exp) begin
                bad++; $display("FAIL defaults_pop%0d: data=%h empty=%b want %h 0", k, m_rd_data, m_empty, exp);
            end
            m_rd_en = 1'b1; @(negedge clk); m_rd_en = 1'b0;
        end
        total++;
        if (m_empty !== 1'b1 || m_fe_n != 0 || m_ov_n != 0) begin
            bad++; $display("FAIL defaults_end: empty=%b fe=%0d ov=%0d want 1 0 0", m_empty, m_fe_n, m_ov_n);
        end
    endtask

    task automatic test_glitch();
        int fe0 = m_fe_n, pe0 = m_pe_n;
        rx[0] = 1'b0;
        repeat (4) @(negedge clk);
        rx[0] = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        total++;
        if (m_count !== 3'd0 || m_fe_n != fe0 || m_pe_n != pe0) begin
            bad++; $display("FAIL glitch_ignored: count=%0d fe+%0d pe+%0d want 0 0 0", m_count, m_fe_n - fe0, m_pe_n - pe0);
        end
        // Receiver must be idle and ready for a real frame.
        drive_frame(0, 9'h03C, 8, -1, 1, 1'b1); q_main.push_back(8'h3C);
        put(0, 1'b1);
        begin
            logic [7:0] exp = q_main.pop_front();
            total++;
            if (m_count !== 3'd1 || m_rd_data !== exp) begin
                bad++; $display("FAIL glitch_recover: count=%0d data=%h want 1 %h", m_count, m_rd_data, exp);
            end
            m_rd_en = 1'b1; @(negedge clk); m_rd_en = 1'b0;
        end
    endtask

    task automatic test_back_to_back();
        drive_frame(0, 9'h0FF, 8, -1, 1, 1'b1); q_main.push_back(8'hFF);
        drive_frame(0, 9'h000, 8, -1, 1, 1'b1); q_main.push_back(8'h00);
        drive_frame(0, 9'h0A3, 8, -1, 1, 1'b1); q_main.push_back(8'hA3);
        put(0, 1'b1);
        total++;
        if (m_count !== 3'd3 || m_fe_n != 0) begin
            bad++; $display("FAIL b2b_count: count=%0d fe=%0d want 3 0", m_count, m_fe_n);
        end
        while (q_main.size() > 0) begin
            logic [7:0] exp = q_main.pop_front();
            total++;
            if (m_rd_data !== exp) begin
                bad++; $display("FAIL b2b_data: got %h want %h", m_rd_data, exp);
            end
            m_rd_en = 1'b1; @(negedge clk); m_rd_en = 1'b0;
        end
        // Reads while empty must not underflow.
        m_rd_en = 1'b1;
        repeat (3) @(negedge clk);
        m_rd_en = 1'b0;
        total++;
        if (m_count !== 3'd0 || m_empty !== 1'b1) begin
            bad++; $display("FAIL underflow: count=%0d empty=%b want 0 1", m_count, m_empty);
        end
    endtask

    task automatic test_parity();
        // 0x2A has three ones: parity bit 1 makes the total even.
        drive_frame(1, 9'h02A, 7, 1, 1, 1'b1); q_even.push_back(7'h2A);
        put(1, 1'b1);
        // 0x15 has three ones: parity bit 0 leaves the total odd.
        drive_frame(1, 9'h015, 7, 0, 1, 1'b1); q_odd.push_back(7'h15);
        put(1, 1'b1);
        total++;
        if (e_pe_n != 1 || o_pe_n != 1 || e_fe_n != 0 || o_fe_n != 0) begin
            bad++; $display("FAIL parity_pulses: even pe=%0d odd pe=%0d fe=%0d/%0d want 1 1 0 0", e_pe_n, o_pe_n, e_fe_n, o_fe_n);
        end
        total++;
        if (e_count !== 3'd1 || o_count !== 3'd1) begin
            bad++; $display("FAIL parity_counts: even=%0d odd=%0d want 1 1", e_count, o_count);
        end
        begin
            logic [6:0] ee = q_even.pop_front();
            logic [6:0] oe = q_odd.pop_front();
            total++;
            if (e_rd_data !== ee) begin
                bad++; $display("FAIL parity_even_data: got %h want %h", e_rd_data, ee);
            end
            total++;
            if (o_rd_data !== oe) begin
                bad++; $display("FAIL parity_odd_data: got %h want %h", o_rd_data, oe);
            end
            e_rd_en = 1'b1; o_rd_en = 1'b1; @(negedge clk); e_rd_en = 1'b0; o_rd_en = 1'b0;
        end
    endtask

    task automatic test_stop2();
        drive_frame(2, 9'h05A, 8, -1, 2, 1'b0);
        repeat (3 * 11 * CPB) @(negedge clk);
        rx[2] = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        total++;
        if (t_fe_n != 1 || t_pe_n != 0 || t_count !== 3'd0) begin
            bad++; $display("FAIL stop2_break: fe=%0d pe=%0d count=%0d want 1 0 0", t_fe_n, t_pe_n, t_count);
        end
        drive_frame(2, 9'h011, 8, -1, 2, 1'b1); q_two.push_back(8'h11);
        put(2, 1'b1);
        begin
            logic [7:0] exp = q_two.pop_front();
            total++;
            if (t_count !== 3'd1 || t_rd_data !== exp || t_fe_n != 1) begin
                bad++; $display("FAIL stop2_recover: count=%0d data=%h fe=%0d want 1 %h 1", t_count, t_rd_data, t_fe_n, exp);
            end
            t_rd_en = 1'b1; @(negedge clk); t_rd_en = 1'b0;
        end
    endtask

    task automatic test_overrun();
        int ov0 = m_ov_n;
        for (int k = 1; k <= 5; k++) begin
            logic [8:0] d = 9'(k);
            drive_frame(0, d, 8, -1, 1, 1'b1);
            if (k <= 4) q_main.push_back(8'(k));
            put(0, 1'b1);
        end
        total++;
        if (m_full !== 1'b1 || m_count !== 3'd4 || m_ov_n != ov0 + 1) begin
            bad++; $display("FAIL overrun_5th: full=%b count=%0d ov+%0d want 1 4 1", m_full, m_count, m_ov_n - ov0);
        end
        // Sixth frame: rd_en lands on the push cycle (2 sync + mid-stop + 1).
        fork
            drive_frame(0, 9'h006, 8, -1, 1, 1'b1);
            begin
                logic [7:0] exp;
                repeat (155) @(negedge clk);
                exp = q_main.pop_front();
                total++;
                if (m_rd_data !== exp) begin
                    bad++; $display("FAIL overrun_head: got %h want %h", m_rd_data, exp);
                end
                m_rd_en = 1'b1; @(negedge clk); m_rd_en = 1'b0;
            end
        join
        q_main.push_back(8'h06);
        put(0, 1'b1);
        total++;
        if (m_count !== 3'd4 || m_ov_n != ov0 + 1) begin
            bad++; $display("FAIL overrun_poppush: count=%0d ov+%0d want 4 1", m_count, m_ov_n - ov0);
        end
        while (q_main.size() > 0) begin
            logic [7:0] exp = q_main.pop_front();
            total++;
            if (m_rd_data !== exp || m_empty !== 1'b0) begin
                bad++; $display("FAIL overrun_drain: got %h empty=%b want %h 0", m_rd_data, m_empty, exp);
            end
            m_rd_en = 1'b1; @(negedge clk); m_rd_en = 1'b0;
        end
        total++;
        if (m_empty !== 1'b1) begin
            bad++; $display("FAIL overrun_empty: got %b want 1", m_empty);
        end
    endtask

    task automatic test_reset_midframe();
        int fe0 = m_fe_n, pe0 = m_pe_n, ov0 = m_ov_n;
        // Leave one word queued so the reset has something to clear.
        drive_frame(0, 9'h033, 8, -1, 1, 1'b1);
        put(0, 1'b1);
        // Start bit plus data bits 0..2, then half of bit 3 (0x5A: 0,1,0,1).
        put(0, 1'b0);
        put(0, 1'b0); put(0, 1'b1); put(0, 1'b0);
        rx[0] = 1'b1;
        repeat (CPB / 2) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if (m_empty !== 1'b1 || m_count !== 3'd0 || m_full !== 1'b0) begin
            bad++; $display("FAIL midreset_during: empty=%b count=%0d full=%b want 1 0 0", m_empty, m_count, m_full);
        end
        reset = 1'b0;
        repeat (4 * CPB) @(negedge clk);
        total++;
        if (m_empty !== 1'b1 || m_fe_n != fe0 || m_pe_n != pe0 || m_ov_n != ov0) begin
            bad++; $display("FAIL midreset_after: empty=%b fe+%0d pe+%0d ov+%0d want 1 0 0 0", m_empty, m_fe_n - fe0, m_pe_n - pe0, m_ov_n - ov0);
        end
        drive_frame(0, 9'h0A5, 8, -1, 1, 1'b1); q_main.push_back(8'hA5);
        put(0, 1'b1);
        begin
            logic [7:0] exp = q_main.pop_front();
            total++;
            if (m_count !== 3'd1 || m_rd_data !== exp) begin
                bad++; $display("FAIL midreset_next: count=%0d data=%h want 1 %h", m_count, m_rd_data, exp);
            end
            m_rd_en = 1'b1; @(negedge clk); m_rd_en = 1'b0;
        end
    endtask

    initial begin
        rx      = 3'b111;
        reset   = 1'b1;
        m_rd_en = 1'b0;
        e_rd_en = 1'b0;
        o_rd_en = 1'b0;
        t_rd_en = 1'b0;
        @(negedge clk);
        test_reset();
        test_defaults();
        test_glitch();
        test_back_to_back();
        test_parity();
        test_stop2();
        test_overrun();
        test_reset_midframe();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
